// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcode/state types and defaults for the ALU command front end
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SHL,
        OP_SHR,
        OP_NOT
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_DONE
    } state_e;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/alu_seq_ctrl_core.sv
// alu_core: combinational 8-bit ALU returning result, carry/borrow/shift-out and zero
module alu_core
    import alu_seq_pkg::*;
(
    input  op_e        op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] r,
    output logic       c,
    output logic       z
);

    always_comb begin
        r = '0;
        c = 1'b0;
        case (op)
            OP_ADD:  {c, r} = {1'b0, a} + {1'b0, b};
            OP_SUB:  {c, r} = {1'b0, a} - {1'b0, b};
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SHL:  {c, r} = {a, 1'b0};
            OP_SHR:  {r, c} = {1'b0, a};
            OP_NOT:  r = ~a;
            default: r = '0;
        endcase
    end

    assign z = (r == 8'h00);

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: 3-byte command sequencer with async strobe/ack handshake around alu_core
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       wr_strobe,
    input  logic [7:0] wr_data,
    input  logic       rd_ack,
    output logic       busy,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       flag_zero,
    output logic       flag_carry,
    output logic       err_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    // bit 0 carries wr_strobe, bit 1 carries rd_ack through identical sync chains
    logic [SYNC_STAGES-1:0][1:0] sync;
    logic [1:0]    sync_d;
    logic          stb_p, ack_p;
    state_e        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    op_e           op, op_n;
    logic [7:0]    a, a_n, b, b_n, r, res_data_n;
    logic          c, z, zero_n, carry_n, valid_n, err_n;

    assign {ack_p, stb_p} = sync[SYNC_STAGES-1] & ~sync_d;
    assign busy = (state == S_GET_A) || (state == S_GET_B) || (state == S_EXEC);

    alu_core u_core (.op(op), .a(a), .b(b), .r(r), .c(c), .z(z));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync        <= '0;
            sync_d      <= '0;
            state       <= S_IDLE;
            cnt         <= '0;
            op          <= OP_ADD;
            a           <= '0;
            b           <= '0;
            res_data    <= '0;
            flag_zero   <= 1'b0;
            flag_carry  <= 1'b0;
            res_valid   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], rd_ack, wr_strobe};
            sync_d      <= sync[SYNC_STAGES-1];
            state       <= state_n;
            cnt         <= cnt_n;
            op          <= op_n;
            a           <= a_n;
            b           <= b_n;
            res_data    <= res_data_n;
            flag_zero   <= zero_n;
            flag_carry  <= carry_n;
            res_valid   <= valid_n;
            err_timeout <= err_n;
        end
    end

    // counter defaults to zero so it is clear on every entry into GET_A/GET_B
    always_comb begin
        state_n    = state;
        cnt_n      = '0;
        op_n       = op;
        a_n        = a;
        b_n        = b;
        res_data_n = res_data;
        zero_n     = flag_zero;
        carry_n    = flag_carry;
        valid_n    = res_valid;
        err_n      = 1'b0;
        if (!ena) begin
            state_n = S_IDLE;
            valid_n = 1'b0;
        end else begin
            case (state)
                S_IDLE: if (stb_p) begin
                    op_n    = op_e'(wr_data[2:0]);
                    state_n = S_GET_A;
                end
                S_GET_A, S_GET_B: begin
                    if (stb_p) begin
                        if (state == S_GET_A) begin
                            a_n     = wr_data;
                            state_n = S_GET_B;
                        end else begin
                            b_n     = wr_data;
                            state_n = S_EXEC;
                        end
                    end else if (cnt == CW'(TIMEOUT_CYC)) begin
                        state_n = S_IDLE;
                        op_n    = OP_ADD;
                        a_n     = '0;
                        b_n     = '0;
                        err_n   = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_EXEC: begin
                    res_data_n = r;
                    zero_n     = z;
                    carry_n    = c;
                    valid_n    = 1'b1;
                    state_n    = S_DONE;
                end
                S_DONE: if (stb_p) begin
                    op_n    = op_e'(wr_data[2:0]);
                    valid_n = 1'b0;
                    state_n = S_GET_A;
                end else if (ack_p) begin
                    valid_n = 1'b0;
                    state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed bench with a per-cycle reference model of the command sequencer
module tb_alu_seq_ctrl;

    localparam int S  = 2;
    localparam int TO = 255;

    logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1, wr_strobe = 1'b0, rd_ack = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       busy, res_valid, flag_zero, flag_carry, err_timeout;
    logic [7:0] res_data;

    int errors = 0, checks = 0;
    bit run = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.SYNC_STAGES(S), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wr_strobe(wr_strobe), .wr_data(wr_data),
        .rd_ack(rd_ack), .busy(busy), .res_valid(res_valid), .res_data(res_data),
        .flag_zero(flag_zero), .flag_carry(flag_carry), .err_timeout(err_timeout)
    );

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference ALU in plain integer arithmetic: returns {carry, result}
    function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int x;
        case (op)
            3'd0: begin x = int'(a) + int'(b); return {x > 255, 8'(x)}; end
            3'd1: begin x = int'(a) - int'(b); return {x < 0, 8'(x)}; end
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: begin x = int'(a) * 2; return {a >= 8'd128, 8'(x)}; end
            3'd6: return {a[0], 8'(int'(a) / 2)};
            default: return {1'b0, 8'(255 - int'(a))};
        endcase
    endfunction

    // model: phase counts bytes received (0 idle, 1 have op, 2 have A, 3 exec, 4 done)
    logic [S:0] sh_s = '0, sh_a = '0;
    int         m_ph = 0, m_cnt = 0;
    logic [2:0] m_op = '0;
    logic [7:0] m_a = '0, m_b = '0, m_res = '0;
    logic       m_z = 0, m_c = 0, m_valid = 0, m_err = 0;
    logic [8:0] m_alu;
    wire        sp = sh_s[S-1] & ~sh_s[S];
    wire        ap = sh_a[S-1] & ~sh_a[S];

    assign m_alu = ref_alu(m_op, m_a, m_b);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_s <= '0; sh_a <= '0; m_ph <= 0; m_cnt <= 0; m_op <= '0; m_a <= '0; m_b <= '0;
            m_res <= '0; m_z <= 0; m_c <= 0; m_valid <= 0; m_err <= 0;
        end else begin
            sh_s  <= {sh_s[S-1:0], wr_strobe};
            sh_a  <= {sh_a[S-1:0], rd_ack};
            m_err <= 0;
            if (!ena) begin
                m_ph <= 0; m_valid <= 0; m_cnt <= 0;
            end else case (m_ph)
                0: if (sp) begin m_op <= wr_data[2:0]; m_ph <= 1; m_cnt <= 0; end
                1, 2: if (sp) begin
                    if (m_ph == 1) m_a <= wr_data; else m_b <= wr_data;
                    m_ph <= m_ph + 1; m_cnt <= 0;
                end else if (m_cnt == TO) begin
                    m_ph <= 0; m_err <= 1; m_cnt <= 0;
                end else m_cnt <= m_cnt + 1;
                3: begin
                    m_res <= m_alu[7:0]; m_c <= m_alu[8]; m_z <= (m_alu[7:0] == 8'h00);
                    m_valid <= 1; m_ph <= 4;
                end
                default: if (sp) begin
                    m_op <= wr_data[2:0]; m_ph <= 1; m_valid <= 0; m_cnt <= 0;
                end else if (ap) begin
                    m_valid <= 0; m_ph <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) if (run && rst_n) begin
        chk("busy", busy, (m_ph >= 1 && m_ph <= 3));
        chk("res_valid", res_valid, m_valid);
        chk("res_data", res_data, m_res);
        chk("flag_zero", flag_zero, m_z);
        chk("flag_carry", flag_carry, m_c);
        chk("err_timeout", err_timeout, m_err);
        chk("busy_and_valid", busy & res_valid, 0);
    end

    task automatic send_byte(input logic [7:0] d);
        wr_data = d; wr_strobe = 1;
        repeat (4) @(negedge clk);
        wr_strobe = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_last(input logic [7:0] d, input logic [7:0] er, input logic ec, input logic ez, input string tag);
        int n = 0;
        wr_data = d; wr_strobe = 1;
        do begin @(negedge clk); n++; end while (!res_valid && n < 20);
        chk({tag, " latency"}, 9'(n), 9'(S + 2));
        chk({tag, " res"}, res_data, er);
        chk({tag, " carry"}, flag_carry, ec);
        chk({tag, " zero"}, flag_zero, ez);
        wr_strobe = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic ec, input logic ez, input string tag);
        send_byte(op);
        send_byte(a);
        send_last(b, er, ec, ez, tag);
    endtask

    task automatic ack();
        int n = 0;
        rd_ack = 1;
        do begin @(negedge clk); n++; end while (res_valid && n < 20);
        chk("ack latency", 9'(n), 9'(S + 1));
        rd_ack = 0;
        repeat (4) @(negedge clk);
        chk("ack idle busy", busy, 0);
    endtask

    initial begin
        #1;
        chk("reset busy", busy, 0);
        chk("reset valid", res_valid, 0);
        chk("reset data", res_data, 0);
        chk("reset err", err_timeout, 0);
        repeat (2) @(negedge clk);
        rst_n = 1; run = 1;
        repeat (2) @(negedge clk);

        cmd(8'h00, 8'hF0, 8'h20, 8'h10, 1, 0, "add carry");
        ack();
        chk("ack keeps data", res_data, 8'h10);
        cmd(8'h00, 8'h80, 8'h80, 8'h00, 1, 1, "add wrap");
        ack();
        cmd(8'h01, 8'h05, 8'h05, 8'h00, 0, 1, "sub equal");
        ack();
        cmd(8'h01, 8'h03, 8'h05, 8'hFE, 1, 0, "sub borrow");
        ack();
        cmd(8'h05, 8'h81, 8'h00, 8'h02, 1, 0, "shl");
        ack();
        cmd(8'h06, 8'h81, 8'h00, 8'h40, 1, 0, "shr");

        send_byte(8'h04);
        chk("b2b clears valid", res_valid, 0);
        chk("b2b busy", busy, 1);
        send_byte(8'h3C);
        send_last(8'h0F, 8'h33, 0, 0, "xor b2b");
        cmd(8'hFF, 8'h0F, 8'h00, 8'hF0, 0, 0, "not hi bits");
        ack();

        begin
            int n;
            wr_data = 8'h00; wr_strobe = 1;
            for (n = 1; n < 400; n++) begin
                @(negedge clk);
                if (n == 4) wr_strobe = 0;
                if (err_timeout) break;
            end
            chk("timeout cycle", 9'(n), 9'(S + TO + 2));
            @(negedge clk);
            chk("timeout pulse width", err_timeout, 0);
            chk("timeout busy", busy, 0);
        end

        begin
            bit seen = 0;
            wr_data = 8'h00; wr_strobe = 1;
            for (int n = 1; n <= 300; n++) begin
                @(negedge clk);
                if (n == 4) wr_strobe = 0;
                if (n == TO + 1) begin wr_data = 8'h11; wr_strobe = 1; end
                if (n == TO + 5) wr_strobe = 0;
                if (err_timeout) seen = 1;
            end
            chk("expiry no err", seen, 0);
            chk("expiry busy", busy, 1);
            send_last(8'h22, 8'h33, 0, 0, "expiry add");
        end

        send_byte(8'h02);
        send_byte(8'hAA);
        rst_n = 0;
        #1;
        chk("rst busy", busy, 0);
        chk("rst valid", res_valid, 0);
        chk("rst data", res_data, 0);
        chk("rst carry", flag_carry, 0);
        chk("rst zero", flag_zero, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        cmd(8'h02, 8'hAA, 8'h0F, 8'h0A, 0, 0, "and after reset");

        ena = 0;
        @(negedge clk);
        chk("ena valid", res_valid, 0);
        send_byte(8'h03);
        repeat (4) @(negedge clk);
        chk("ena ignores strobe", busy, 0);
        ena = 1;
        repeat (3) @(negedge clk);
        chk("ena back idle", busy, 0);
        cmd(8'h03, 8'h50, 8'h0A, 8'h5A, 0, 0, "or after ena");
        ack();

        run = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Pin-level command front end for the 8-bit ALU on a Tiny Tapeout tile. It accepts a 3-byte command (opcode, A, B) over one 8-bit data bus qualified by an asynchronous write strobe, then executes the operation and holds a registered result with flags until the host acknowledges it. It is the requester side of the operand/result interface: the combinational ALU is the responder, and this block adds sequencing, synchronisation and flow control.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the strobe/ack synchronisers (minimum 2)
TIMEOUT_CYC, 255, idle clocks allowed between command bytes before the command is aborted (minimum 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  tile enable; low forces IDLE
wr_strobe  in  1  asynchronous host write strobe; each rising edge delivers one byte
wr_data  in  8  command byte; must be stable while wr_strobe is high
rd_ack  in  1  asynchronous host acknowledge; a rising edge releases the result
busy  out  1  high in GET_A, GET_B and EXEC
res_valid  out  1  result held and valid
res_data  out  8  registered ALU result
flag_zero  out  1  res_data == 0
flag_carry  out  1  carry, borrow or shifted-out bit
err_timeout  out  1  one-cycle pulse when a command aborts

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, all outputs 0, synchronisers 0, timeout counter 0, operand registers 0.
- wr_strobe and rd_ack each pass through SYNC_STAGES FFs, then a rising-edge detector. stb_p / ack_p is a 1-cycle pulse issued SYNC_STAGES+1 clocks after the pin edge is first sampled.
- wr_data is captured in the same cycle as stb_p. It is not synchronised; the host holds it stable.
- FSM states: IDLE, GET_A, GET_B, EXEC, DONE.
  - IDLE: on stb_p, op <= wr_data[2:0], go to GET_A. wr_data[7:3] are ignored.
  - GET_A: on stb_p, A <= wr_data, go to GET_B.
  - GET_B: on stb_p, B <= wr_data, go to EXEC.
  - EXEC: lasts exactly 1 cycle. Result and flags are registered; go to DONE. res_valid rises in the first DONE cycle, 2 clocks after the B pulse.
  - DONE: outputs held stable.
    - ack_p: clear res_valid, go to IDLE. res_data and flags keep their last values.
    - stb_p: treat the byte as a new opcode, clear res_valid, go to GET_A.
    - ack_p and stb_p in the same cycle: stb_p wins (new opcode, GET_A).
- Timeout:
  - The counter clears on entry to GET_A or GET_B and on every stb_p.
  - Otherwise it increments in GET_A and GET_B.
  - When it reaches TIMEOUT_CYC: go to IDLE, discard operands, pulse err_timeout for 1 cycle.
  - A stb_p in that same cycle wins; no timeout is raised.
- ena=0: synchronous return to IDLE on the next edge. res_valid clears, busy clears, pulses are ignored, synchronisers keep running. This has priority over every transition.
- ack_p in IDLE, GET_A, GET_B or EXEC is ignored.
- Opcodes (result is 8 bits, modular):
  - 0 ADD: {C,R} = A+B (9-bit).
  - 1 SUB: R = A-B; C = 1 when A<B (borrow).
  - 2 AND, 3 OR, 4 XOR: C = 0.
  - 5 SHL: R = A<<1; C = A[7].
  - 6 SHR: R = A>>1 (logical); C = A[0].
  - 7 NOT: R = ~A; C = 0.
- Z = (R == 8'h00) for every opcode.
- busy and res_valid are never both high.

Decomposition:
- Package alu_seq_pkg:
  - 3-bit opcode enum with constants OP_ADD..OP_NOT;
  - FSM state enum;
  - default SYNC_STAGES and TIMEOUT_CYC.
- Sub-module alu_core: purely combinational (op, A, B) -> (R, C, Z), instanced once and registered in EXEC. The synchroniser + edge detector is small enough to stay inline; instance the same logic twice, once for wr_strobe and once for rd_ack.

Test Plan:
- Defaults. Bytes 0x00, 0xF0, 0x20 -> busy high through GET_A..EXEC. Then res_valid=1, res_data=0x10, flag_carry=1, flag_zero=0, 2 clocks after the B pulse.
- SUB. op=1, A=0x05, B=0x05 -> res_data=0x00, flag_zero=1, flag_carry=0. Repeat with A=0x03, B=0x05 -> 0xFE, flag_carry=1.
- Shifts. op=5, A=0x81 -> 0x02, flag_carry=1. op=6, A=0x81 -> 0x40, flag_carry=1.
- Ack and back-to-back. Raise rd_ack in DONE -> res_valid falls SYNC_STAGES+1 clocks later, state IDLE. Raise wr_strobe (0x04) in DONE without ack -> res_valid clears, new XOR command completes correctly.
- Timeout. Send opcode, then wait 255 clocks -> err_timeout 1-cycle pulse, busy=0. A strobe arriving in the expiry cycle -> no error, advance to GET_B.
- Reset and enable. rst_n low mid-GET_B -> all outputs 0 immediately, IDLE. ena low in DONE -> res_valid=0 next clock, strobes ignored until ena=1.
